// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the UART transmit arbiter.
//               ArbState      - arbiter FSM state encoding
//               TX_EN_ASSERT / TX_EN_DEASSERT - levels of the active-low tx_en
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbSend = 2'd1,
    ArbWait = 2'd2,
    ArbHold = 2'd3
  } ArbState;

  localparam logic TX_EN_ASSERT   = 1'b0;
  localparam logic TX_EN_DEASSERT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and UART-side signals of the transmit arbiter.
//               master modport : arbiter view (drives ready, tx_*, status)
//               slave  modport : requester/UART view
//   req_valid/req_last/req_byte : per-requester byte offer, slice i = [8i+7:8i]
//   req_ready                   : one-cycle accept pulse per requester
//   tx_en/tx_byte/tx_complete   : UART transmitter handshake (tx_en active-low)
//   grant_id/busy/err_timeout   : status
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [8*NUM_REQ-1:0]       req_byte;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       tx_en;
  logic [7:0]                 tx_byte;
  logic                       tx_complete;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       busy;
  logic                       err_timeout;

  modport master (
    input  req_valid, req_last, req_byte, tx_complete,
    output req_ready, tx_en, tx_byte, grant_id, busy, err_timeout
  );

  modport slave (
    output req_valid, req_last, req_byte, tx_complete,
    input  req_ready, tx_en, tx_byte, grant_id, busy, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/uart_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_rr_pick
// Description : Combinational round-robin pick. Searches req_i starting one
//               past last_grant_i, wrapping modulo NUM_REQ.
//   req_i        : request vector
//   last_grant_i : previous owner
//   winner_o     : first requester found (meaningless when any_valid_o=0)
//   any_valid_o  : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module uart_arb_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_valid_o
);
  import uart_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic w_found;
  int   w_idx;

  always_comb begin
    winner_o = last_grant_i;
    w_found  = 1'b0;
    w_idx    = 0;
    // Offset 1 is the highest priority, offset NUM_REQ (the last owner) the lowest.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(last_grant_i) + k) % NUM_REQ;
      if (!w_found && req_i[w_idx]) begin
        w_found  = 1'b1;
        winner_o = IDX_W'(w_idx);
      end
    end
    any_valid_o = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NUM_REQ byte producers with
//               round-robin selection, packet lock and a watchdog.
//   sourceClk : system clock
//   reset     : asynchronous active-low reset
//   bus       : uart_tx_arbiter_if master modport (requesters + UART + status)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               sourceClk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);
  import uart_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_LIMIT  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE = ArbIdle;
  localparam logic [1:0] ST_SEND = ArbSend;
  localparam logic [1:0] ST_WAIT = ArbWait;
  localparam logic [1:0] ST_HOLD = ArbHold;

  logic [1:0]         state_q,      state_d;
  logic               locked_q,     locked_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [TMR_W-1:0]   timer_q,      timer_d;
  logic               prev_txc_q;
  logic               tx_en_q,      tx_en_d;
  logic [7:0]         tx_byte_q,    tx_byte_d;
  logic [NUM_REQ-1:0] req_ready_q,  req_ready_d;
  logic [IDX_W-1:0]   grant_q,      grant_d;
  logic               busy_q,       busy_d;
  logic               err_q,        err_d;

  logic [IDX_W-1:0]   w_winner;
  logic               w_any;
  logic               w_txc_rise;
  logic [TMR_W-1:0]   w_timer_inc;
  logic               w_expire;

  uart_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .winner_o     (w_winner),
    .any_valid_o  (w_any)
  );

  assign w_txc_rise  = bus.tx_complete & ~prev_txc_q;
  assign w_timer_inc = (timer_q == TMR_LIMIT) ? timer_q : timer_q + TMR_W'(1);
  // Expiry fires on the cycle whose count reaches the limit.
  assign w_expire    = (w_timer_inc == TMR_LIMIT);

  always_comb begin
    state_d      = state_q;
    locked_d     = locked_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    tx_en_d      = TX_EN_DEASSERT;
    tx_byte_d    = tx_byte_q;
    req_ready_d  = '0;
    grant_d      = grant_q;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          tx_byte_d             = bus.req_byte[8*w_winner +: 8];
          grant_d               = w_winner;
          req_ready_d[w_winner] = 1'b1;
          locked_d              = ~bus.req_last[w_winner];
          state_d               = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_en_d = TX_EN_ASSERT;
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = w_timer_inc;
        // timer_q==0 marks the first WAIT cycle, where a completion edge
        // can only be stale and is ignored. Completion beats expiry.
        if (w_txc_rise && (timer_q != '0)) begin
          if (locked_q) begin
            timer_d = '0;
            state_d = ST_HOLD;
          end else begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end else if (w_expire) begin
          err_d        = 1'b1;
          locked_d     = 1'b0;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      ST_HOLD: begin
        timer_d = w_timer_inc;
        if (bus.req_valid[grant_q]) begin
          tx_byte_d            = bus.req_byte[8*grant_q +: 8];
          req_ready_d[grant_q] = 1'b1;
          locked_d             = ~bus.req_last[grant_q];
          state_d              = ST_SEND;
        end else if (w_expire) begin
          err_d        = 1'b1;
          locked_d     = 1'b0;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      locked_q     <= 1'b0;
      last_grant_q <= LAST_RESET;
      timer_q      <= '0;
      prev_txc_q   <= 1'b0;
      tx_en_q      <= TX_EN_DEASSERT;
      tx_byte_q    <= 8'h00;
      req_ready_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      prev_txc_q   <= bus.tx_complete;
      tx_en_q      <= tx_en_d;
      tx_byte_q    <= tx_byte_d;
      req_ready_q  <= req_ready_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule
`default_nettype wire
